// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding and constants for the UART TX scheduler
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_rr_arb2.sv
// rtl/uart_rr_arb2.sv - two-way round-robin grant with registered priority pointer
// Lock inputs exist only when UART_TX_SCHED_LOCK_EN is defined.
module uart_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
`ifdef UART_TX_SCHED_LOCK_EN
  input  logic [1:0] lock,
`endif
  input  logic       accept,
  output logic [1:0] grant
);

  logic rr;
  logic hold;

  always_comb begin
    grant = 2'b00;
    if (rr == 1'b0) begin
      if (valid[0])      grant = 2'b01;
      else if (valid[1]) grant = 2'b10;
    end else begin
      if (valid[1])      grant = 2'b10;
      else if (valid[0]) grant = 2'b01;
    end
  end

`ifdef UART_TX_SCHED_LOCK_EN
  // Only the winner's lock counts, so an idle lock holder never blocks the other side.
  assign hold = |(grant & lock);
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr <= 1'b0;
    end else if (accept && !hold) begin
      rr <= ~grant[1];
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - two-requester round-robin scheduler feeding an 8N1/8N2 UART transmitter
// Optional per-requester priority lock via UART_TX_SCHED_LOCK_EN.
module uart_tx_sched #(
  parameter int STOP_BITS = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_txclk_en,
  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_data,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_data,
  output logic       o_req1_ready,
`ifdef UART_TX_SCHED_LOCK_EN
  input  logic       i_req0_lock,
  input  logic       i_req1_lock,
`endif
  output logic       o_uart_tx,
  output logic       o_busy,
  output logic       o_tx_done
);
  import uart_pkg::*;

  localparam logic STOP_LAST = (STOP_BITS == STOP_BITS_MAX);

  tx_state_t              state, state_nx;
  logic [UART_DATA_W-1:0] sh, sh_nx;
  logic [2:0]             bit_cnt, bit_cnt_nx;
  logic                   stop_cnt, stop_cnt_nx;
  logic                   tx, tx_nx;
  logic                   done, done_nx;
  logic [1:0]             grant;
  logic                   idle;
  logic                   accept;

  assign idle         = (state == ST_IDLE);
  assign o_req0_ready = idle & grant[0];
  assign o_req1_ready = idle & grant[1];
  assign accept       = (o_req0_ready & i_req0_valid) | (o_req1_ready & i_req1_valid);

  uart_rr_arb2 u_arb (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .valid  ({i_req1_valid, i_req0_valid}),
`ifdef UART_TX_SCHED_LOCK_EN
    .lock   ({i_req1_lock, i_req0_lock}),
`endif
    .accept (accept),
    .grant  (grant)
  );

  always_comb begin
    state_nx    = state;
    sh_nx       = sh;
    bit_cnt_nx  = bit_cnt;
    stop_cnt_nx = stop_cnt;
    tx_nx       = tx;
    done_nx     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          sh_nx    = grant[1] ? i_req1_data : i_req0_data;
          state_nx = ST_ARM;
        end
      end
      // ARM absorbs the partial strobe period so every bit lasts a full period.
      ST_ARM: begin
        if (i_txclk_en) begin
          state_nx = ST_START;
          tx_nx    = 1'b0;
        end
      end
      ST_START: begin
        if (i_txclk_en) begin
          state_nx   = ST_DATA;
          tx_nx      = sh[0];
          bit_cnt_nx = 3'd0;
        end
      end
      ST_DATA: begin
        if (i_txclk_en) begin
          if (bit_cnt == 3'd7) begin
            state_nx    = ST_STOP;
            tx_nx       = 1'b1;
            stop_cnt_nx = 1'b0;
          end else begin
            tx_nx      = sh[bit_cnt + 3'd1];
            bit_cnt_nx = bit_cnt + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (i_txclk_en) begin
          if (stop_cnt == STOP_LAST) begin
            state_nx = ST_IDLE;
            done_nx  = 1'b1;
          end else begin
            stop_cnt_nx = 1'b1;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      sh       <= '0;
      bit_cnt  <= 3'd0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      sh       <= sh_nx;
      bit_cnt  <= bit_cnt_nx;
      stop_cnt <= stop_cnt_nx;
      tx       <= tx_nx;
      done     <= done_nx;
    end
  end

  assign o_uart_tx = tx;
  assign o_busy    = ~idle;
  assign o_tx_done = done;

endmodule
